// File: rtl/xfcp_cobs_pkg.sv
// Shared COBS definitions for the XFCP UART decoder and its companion encoder.
package xfcp_cobs_pkg;

  localparam logic [7:0] COBS_DELIM    = 8'h00;
  localparam logic [7:0] COBS_MAX_CODE = 8'hFF;

  // CODE: the next non-zero byte is a group code; DATA: inside a group.
  typedef enum logic {
    CODE = 1'b0,
    DATA = 1'b1
  } cobs_state_e;

  // One byte staged in the hold register, waiting to learn whether it is last.
  typedef struct packed {
    logic [7:0] data;
    logic       valid;
  } hold_t;

endpackage

// File: rtl/xfcp_cobs_decode_if.sv
// Byte-wide AXI-stream bundle used on both sides of the COBS decoder.
interface xfcp_cobs_decode_if;

  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tlast;
  logic       tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);

endinterface

// File: rtl/xfcp_cobs_decode.sv
// COBS frame decoder: raw UART RX bytes in, XFCP AXI-stream packets out.
// Each decoded byte is held for one accepted input byte so that tlast can be
// attached when the 0x00 delimiter arrives.
module xfcp_cobs_decode
  import xfcp_cobs_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  xfcp_cobs_decode_if.slave         s_axis,
  xfcp_cobs_decode_if.master        m_axis,
  output logic                      error_bad_frame
);

  cobs_state_e r_state,        w_state_nxt;
  logic [7:0]  r_remaining,    w_remaining_nxt;
  logic        r_zero_pending, w_zero_pending_nxt;
  hold_t       r_hold,         w_hold_nxt;
  logic [7:0]  r_o_data,       w_o_data_nxt;
  logic        r_o_valid,      w_o_valid_nxt;
  logic        r_o_last,       w_o_last_nxt;
  logic        r_o_user,       w_o_user_nxt;
  logic        r_err,          w_err_nxt;

  logic        w_ready;
  logic        w_accept;
  logic [7:0]  w_byte;

  // Input acceptance depends only on whether the output register can take a beat.
  assign w_ready  = !r_o_valid || m_axis.tready;
  assign w_accept = s_axis.tvalid && w_ready;
  assign w_byte   = s_axis.tdata;

  // Next-state and datapath decode for one accepted byte.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch can be inferred.
    w_state_nxt        = r_state;
    w_remaining_nxt    = r_remaining;
    w_zero_pending_nxt = r_zero_pending;
    w_hold_nxt         = r_hold;
    w_o_data_nxt       = r_o_data;
    w_o_valid_nxt      = r_o_valid && !m_axis.tready;
    w_o_last_nxt       = r_o_last;
    w_o_user_nxt       = r_o_user;
    w_err_nxt          = 1'b0;

    if (w_accept) begin
      if (w_byte == COBS_DELIM) begin
        // Frame delimiter: the held byte is the last of the packet.
        if (r_hold.valid) begin
          w_o_data_nxt  = r_hold.data;
          w_o_valid_nxt = 1'b1;
          w_o_last_nxt  = 1'b1;
          w_o_user_nxt  = (r_state == DATA);
        end
        w_err_nxt          = (r_state == DATA);
        w_hold_nxt.valid   = 1'b0;
        w_zero_pending_nxt = 1'b0;
        w_remaining_nxt    = 8'd0;
        w_state_nxt        = CODE;
      end else if (r_state == CODE) begin
        // A new code byte closes the previous group, releasing its implied zero.
        if (r_zero_pending) begin
          if (r_hold.valid) begin
            w_o_data_nxt  = r_hold.data;
            w_o_valid_nxt = 1'b1;
            w_o_last_nxt  = 1'b0;
            w_o_user_nxt  = 1'b0;
          end
          w_hold_nxt = '{data: 8'h00, valid: 1'b1};
        end
        w_zero_pending_nxt = (w_byte != COBS_MAX_CODE);
        w_remaining_nxt    = w_byte - 8'd1;
        w_state_nxt        = (w_byte > 8'd1) ? DATA : CODE;
      end else begin
        // Data byte: push the previous byte and hold this one.
        if (r_hold.valid) begin
          w_o_data_nxt  = r_hold.data;
          w_o_valid_nxt = 1'b1;
          w_o_last_nxt  = 1'b0;
          w_o_user_nxt  = 1'b0;
        end
        w_hold_nxt      = '{data: w_byte, valid: 1'b1};
        w_remaining_nxt = r_remaining - 8'd1;
        w_state_nxt     = (r_remaining == 8'd1) ? CODE : DATA;
      end
    end
  end

  // State, hold and output registers; reset discards any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register here is a small flop with a defined reset value, and all
    // updates use non-blocking assignments so reads see the pre-edge values.
    if (!rst_n) begin
      r_state        <= CODE;
      r_remaining    <= 8'd0;
      r_zero_pending <= 1'b0;
      r_hold         <= '{data: 8'h00, valid: 1'b0};
      r_o_data       <= 8'h00;
      r_o_valid      <= 1'b0;
      r_o_last       <= 1'b0;
      r_o_user       <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_remaining    <= w_remaining_nxt;
      r_zero_pending <= w_zero_pending_nxt;
      r_hold         <= w_hold_nxt;
      r_o_data       <= w_o_data_nxt;
      r_o_valid      <= w_o_valid_nxt;
      r_o_last       <= w_o_last_nxt;
      r_o_user       <= w_o_user_nxt;
      r_err          <= w_err_nxt;
    end
  end

  assign s_axis.tready   = w_ready;
  assign m_axis.tdata    = r_o_data;
  assign m_axis.tvalid   = r_o_valid;
  assign m_axis.tlast    = r_o_last;
  assign m_axis.tuser    = r_o_user;
  assign error_bad_frame = r_err;

endmodule

// File: tb/tb_xfcp_cobs_decode.sv
// Self-checking bench for xfcp_cobs_decode: directed frames plus randomized
// frames encoded by an independent COBS encoder, with a beat scoreboard.
module tb_xfcp_cobs_decode;

  typedef logic [7:0] byte_q_t[$];
  typedef struct packed {
    logic       user;
    logic       last;
    logic [7:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  logic error_bad_frame;

  xfcp_cobs_decode_if s_if ();
  xfcp_cobs_decode_if m_if ();

  xfcp_cobs_decode dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .s_axis          (s_if),
    .m_axis          (m_if),
    .error_bad_frame (error_bad_frame)
  );

  always #5 clk = ~clk;

  int    checks    = 0;
  int    failures  = 0;
  int    err_count = 0;
  int    exp_errs  = 0;
  int    beat_count = 0;
  beat_t exp_q[$];
  bit    rand_mode    = 1'b0;
  bit    rand_gaps    = 1'b0;
  bit    tready_force = 1'b1;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Downstream ready: forced level or random, updated shortly after each rising edge.
  always @(posedge clk) begin
    #2;
    m_if.tready = rand_mode ? 1'($urandom_range(0, 1)) : tready_force;
  end

  // Output monitor: a beat seen valid&ready at the falling edge transfers on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && m_if.tvalid && m_if.tready) begin
      beat_count++;
      checks++;
      assert (exp_q.size() != 0)
      else begin
        failures++;
        $error("FAIL unexpected_beat observed=%0h expected=none",
               {m_if.tuser, m_if.tlast, m_if.tdata});
      end
      if (exp_q.size() != 0) begin
        beat_t e;
        e = exp_q.pop_front();
        check("beat", 32'({m_if.tuser, m_if.tlast, m_if.tdata}), 32'(e));
      end
    end
    if (rst_n && error_bad_frame) err_count++;
  end

  initial begin
    #900_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation timed out");
  end

  task automatic push_beat(input logic [7:0] d, input logic last, input logic user);
    exp_q.push_back('{user: user, last: last, data: d});
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit done;
    done = 1'b0;
    s_if.tdata  = b;
    s_if.tvalid = 1'b1;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (s_if.tready) done = 1'b1;
    end
    if (!done) check("send_accept", 32'(done), 32'd1);
    @(posedge clk);
    #1;
    s_if.tvalid = 1'b0;
  endtask

  task automatic send_frame(input byte_q_t e);
    foreach (e[i]) begin
      if (rand_gaps && ($urandom_range(0, 3) == 0)) begin
        @(posedge clk);
        #1;
      end
      send_byte(e[i]);
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 4000 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_errs"}, 32'(err_count), 32'(exp_errs));
  endtask

  function automatic void cobs_encode(input byte_q_t p, output byte_q_t e);
    int         idx;
    logic [7:0] code;
    e = {};
    idx = 0;
    e.push_back(8'h00);
    code = 8'h01;
    foreach (p[i]) begin
      if (p[i] == 8'h00) begin
        e[idx] = code;
        idx = e.size();
        e.push_back(8'h00);
        code = 8'h01;
      end else begin
        e.push_back(p[i]);
        code++;
        if (code == 8'hFF) begin
          e[idx] = code;
          idx = e.size();
          e.push_back(8'h00);
          code = 8'h01;
        end
      end
    end
    e[idx] = code;
    e.push_back(8'h00);
  endfunction

  initial begin
    byte_q_t frame;
    byte_q_t payload;
    byte_q_t enc;
    int      beats_before;

    rst_n       = 1'b0;
    s_if.tdata  = 8'h00;
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    s_if.tuser  = 1'b0;

    // Reset values.
    #3;
    check("rst_m_tvalid", 32'(m_if.tvalid), 32'd0);
    check("rst_m_tdata", 32'(m_if.tdata), 32'd0);
    check("rst_m_tlast", 32'(m_if.tlast), 32'd0);
    check("rst_m_tuser", 32'(m_if.tuser), 32'd0);
    check("rst_err", 32'(error_bad_frame), 32'd0);
    check("rst_s_tready", 32'(s_if.tready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic decode: 03 11 22 02 33 00 -> 11 22 00 33(last).
    push_beat(8'h11, 1'b0, 1'b0);
    push_beat(8'h22, 1'b0, 1'b0);
    push_beat(8'h00, 1'b0, 1'b0);
    push_beat(8'h33, 1'b1, 1'b0);
    frame = '{8'h03, 8'h11, 8'h22, 8'h02, 8'h33, 8'h00};
    send_frame(frame);
    drain("basic");

    // Single zero byte: 01 01 00 -> 00(last).
    push_beat(8'h00, 1'b1, 1'b0);
    frame = '{8'h01, 8'h01, 8'h00};
    send_frame(frame);
    drain("single_zero");

    // Empty frames: 00 00 01 00 -> nothing.
    beats_before = beat_count;
    frame = '{8'h00, 8'h00, 8'h01, 8'h00};
    send_frame(frame);
    drain("empty");
    check("empty_no_beats", 32'(beat_count - beats_before), 32'd0);

    // Maximum group: FF 01..FE 00 -> 01..FE, tlast on FE.
    frame = {};
    frame.push_back(8'hFF);
    for (int i = 1; i <= 254; i++) begin
      frame.push_back(8'(i));
      push_beat(8'(i), (i == 254), 1'b0);
    end
    frame.push_back(8'h00);
    send_frame(frame);
    drain("max_group");

    // Truncated group: 04 AA BB 00 -> AA, BB(last, bad) and one error pulse.
    push_beat(8'hAA, 1'b0, 1'b0);
    push_beat(8'hBB, 1'b1, 1'b1);
    send_byte(8'h04);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'h00);
    check("trunc_err_pulse", 32'(error_bad_frame), 32'd1);
    @(posedge clk);
    #1;
    check("trunc_err_clear", 32'(error_bad_frame), 32'd0);
    exp_errs++;
    drain("truncated");
    push_beat(8'h55, 1'b1, 1'b0);
    frame = '{8'h02, 8'h55, 8'h00};
    send_frame(frame);
    drain("after_trunc");

    // Backpressure: stall 10 cycles with 01 in the output register.
    push_beat(8'h01, 1'b0, 1'b0);
    push_beat(8'h02, 1'b0, 1'b0);
    push_beat(8'h03, 1'b0, 1'b0);
    push_beat(8'h04, 1'b1, 1'b0);
    send_byte(8'h05);
    send_byte(8'h01);
    tready_force = 1'b0;
    send_byte(8'h02);
    s_if.tdata  = 8'h03;
    s_if.tvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_s_tready", 32'(s_if.tready), 32'd0);
      check("bp_m_tdata", 32'(m_if.tdata), 32'h01);
      check("bp_m_tvalid", 32'(m_if.tvalid), 32'd1);
    end
    tready_force = 1'b1;
    send_byte(8'h03);
    send_byte(8'h04);
    send_byte(8'h00);
    drain("backpressure");

    // Reset mid-frame: AA waits in the output register, BB in the hold register.
    send_byte(8'h04);
    tready_force = 1'b0;
    send_byte(8'hAA);
    send_byte(8'hBB);
    check("pre_rst_m_tvalid", 32'(m_if.tvalid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_m_tvalid", 32'(m_if.tvalid), 32'd0);
    check("mid_rst_m_tdata", 32'(m_if.tdata), 32'd0);
    check("mid_rst_m_tlast", 32'(m_if.tlast), 32'd0);
    check("mid_rst_m_tuser", 32'(m_if.tuser), 32'd0);
    check("mid_rst_err", 32'(error_bad_frame), 32'd0);
    check("mid_rst_s_tready", 32'(s_if.tready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tready_force = 1'b1;
    @(posedge clk);
    #1;
    push_beat(8'h77, 1'b1, 1'b0);
    frame = '{8'h02, 8'h77, 8'h00};
    send_frame(frame);
    drain("after_reset");

    // Random frames with random downstream ready and input gaps.
    rand_mode = 1'b1;
    rand_gaps = 1'b1;
    for (int f = 0; f < 100; f++) begin
      int len;
      int zero_div;
      len      = (f % 25 == 24) ? 300 : $urandom_range(0, 40);
      zero_div = (f % 25 == 24) ? 64 : 4;
      payload = {};
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, zero_div - 1) == 0) payload.push_back(8'h00);
        else payload.push_back(8'($urandom_range(1, 255)));
      end
      foreach (payload[i]) push_beat(payload[i], (i == payload.size() - 1), 1'b0);
      cobs_encode(payload, enc);
      send_frame(enc);
    end
    rand_mode = 1'b0;
    drain("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
